jpeg_byte_streamer: RTL

JPEG_BYTE_STREAMER -- requirements
Module: jpeg_byte_streamer

---
 rtl/jpeg_stream_pkg.sv | 20 ++
 rtl/jpeg_tile_addr_gen.sv | 67 ++++++
 rtl/jpeg_byte_streamer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/jpeg_stream_pkg.sv
// Shared definitions for the JPEG byte streamer: FSM states, marker and tile constants.
package jpeg_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LD,
      LEN_W,
      HDR_LD,
      HDR_W,
      DAT_LD,
      DAT_W,
      FIN
   } state_t;

   localparam logic [15:0] EOI_MARKER   = 16'hFFD9;
   localparam int          TILE         = 8;
   localparam int          ORDER_LINEAR = 0;
   localparam int          ORDER_TILED  = 1;

endpackage

// File: rtl/jpeg_tile_addr_gen.sv
// Walks an image in 8x8 tile order and produces byte addresses into a linear buffer.
// Edge tiles are clipped to the image; the walk wraps to address 0 after the last byte.
module jpeg_tile_addr_gen
   import jpeg_stream_pkg::*;
#(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 200,
   parameter int BPP    = 2,
   parameter int AW     = 17
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          step,
   output logic [AW-1:0] addr,
   output logic          last
);

   logic [31:0] b, cx, cy, tx, ty;
   logic [31:0] col, row;
   logic        last_b, last_cx, last_cy, last_tx, last_ty;

   assign col  = tx + cx;
   assign row  = ty + cy;
   assign addr = AW'((row * 32'(WIDTH) + col) * 32'(BPP) + b);

   assign last_b  = (b == 32'(BPP - 1));
   assign last_cx = (cx == 32'(TILE - 1)) || (col == 32'(WIDTH - 1));
   assign last_cy = (cy == 32'(TILE - 1)) || (row == 32'(HEIGHT - 1));
   assign last_tx = (tx + 32'(TILE) >= 32'(WIDTH));
   assign last_ty = (ty + 32'(TILE) >= 32'(HEIGHT));
   assign last    = last_b && last_cx && last_cy && last_tx && last_ty;

   // Nested counters: byte, column in tile, row in tile, tile column, tile row.
   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         b  <= '0;
         cx <= '0;
         cy <= '0;
         tx <= '0;
         ty <= '0;
      end else if (step) begin
         if (!last_b) begin
            b <= b + 32'd1;
         end else begin
            b <= '0;
            if (!last_cx) begin
               cx <= cx + 32'd1;
            end else begin
               cx <= '0;
               if (!last_cy) begin
                  cy <= cy + 32'd1;
               end else begin
                  cy <= '0;
                  if (!last_tx) begin
                     tx <= tx + 32'(TILE);
                  end else begin
                     tx <= '0;
                     ty <= last_ty ? '0 : ty + 32'(TILE);
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/jpeg_byte_streamer.sv
// Streams a JPEG frame byte-by-byte to an SPI slave: length prefix, header ROM, then
// encoder payload (linear or 8x8 tile order), ending early on an FFD9 marker if enabled.
module jpeg_byte_streamer
   import jpeg_stream_pkg::*;
#(
   parameter int WIDTH     = 320,
   parameter int HEIGHT    = 200,
   parameter int BPP       = 2,
   parameter int HDR_SIZE  = 607,
   parameter int HDR_AW    = 10,
   parameter int DATA_AW   = 17,
   parameter int LEN_BYTES = 3,
   parameter int ORDER     = 1,
   parameter int EOI_EN    = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               je_done,
   input  logic               abort,
   input  logic [DATA_AW-1:0] jpeg_size,
   output logic [HDR_AW-1:0]  hd_addr,
   input  logic [7:0]         hd_data,
   output logic [DATA_AW-1:0] je_addr,
   input  logic [7:0]         je_data,
   input  logic               spi_rd,
   output logic [7:0]         spi_data,
   output logic               busy,
   output logic               done
);

   localparam int LW = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;

   state_t             state, state_next;
   logic [DATA_AW-1:0] size_q, pay_cnt, tile_addr;
   logic [LW-1:0]      len_idx;
   logic               hdr_last, eoi_seen, clr;
   logic [31:0]        size_ext;
   logic [7:0]         len_byte;
   // The end-of-image flag is not needed here: the tile walk wraps by itself.
   logic               unused_tile_last;

   assign size_ext = 32'(size_q);
   assign len_byte = 8'(size_ext >> (8 * (LEN_BYTES - 1 - int'(len_idx))));
   assign clr      = (state_next == IDLE);
   assign je_addr  = (ORDER == ORDER_TILED) ? tile_addr : pay_cnt;

   jpeg_tile_addr_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .BPP    (BPP),
      .AW     (DATA_AW)
   ) u_tile (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .step    (state == DAT_LD),
      .addr    (tile_addr),
      .last    (unused_tile_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state and status outputs; abort overrides every transition.
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE:    if (je_done) state_next = LEN_LD;
         LEN_LD:  state_next = LEN_W;
         LEN_W:   if (spi_rd) state_next = (len_idx == LW'(LEN_BYTES - 1)) ? HDR_LD : LEN_LD;
         HDR_LD:  state_next = HDR_W;
         HDR_W: begin
            if (spi_rd) begin
               if (!hdr_last)           state_next = HDR_LD;
               else if (size_q == '0)   state_next = FIN;
               else                     state_next = DAT_LD;
            end
         end
         DAT_LD:  state_next = DAT_W;
         DAT_W:   if (spi_rd) state_next = (pay_cnt == size_q || eoi_seen) ? FIN : DAT_LD;
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   // Byte loading, counters and marker detection; everything clears on the way to IDLE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         size_q   <= '0;
         pay_cnt  <= '0;
         len_idx  <= '0;
         hd_addr  <= '0;
         hdr_last <= 1'b0;
         eoi_seen <= 1'b0;
         spi_data <= 8'h00;
      end else begin
         if (state == IDLE && je_done && !abort) size_q <= jpeg_size;
         case (state)
            LEN_LD: spi_data <= len_byte;
            LEN_W:  if (spi_rd) len_idx <= len_idx + 1'b1;
            HDR_LD: begin
               spi_data <= hd_data;
               hd_addr  <= hd_addr + 1'b1;
               hdr_last <= (hd_addr == HDR_AW'(HDR_SIZE - 1));
            end
            DAT_LD: begin
               spi_data <= je_data;
               pay_cnt  <= pay_cnt + 1'b1;
               // spi_data still holds the previous payload byte here (unless this is the first).
               eoi_seen <= (EOI_EN != 0) && (pay_cnt != '0) && ({spi_data, je_data} == EOI_MARKER);
            end
            default: ;
         endcase
         if (clr) begin
            pay_cnt  <= '0;
            len_idx  <= '0;
            hd_addr  <= '0;
            hdr_last <= 1'b0;
            eoi_seen <= 1'b0;
         end
      end
   end

endmodule
